// File: rtl/bcd_result_converter_if.sv
// ---------------------------------------------------------------------------
// bcd_result_converter_if
//   Handshake and data bundle between the calculator controller (master) and
//   the sequential binary-to-BCD converter (slave).
//
//   start_i : controller requests a conversion of bin_i
//   bin_i   : WIDTH-bit unsigned sum from the adder stage (carry included)
//   busy_o  : conversion in progress
//   done_o  : one-cycle pulse when bcd_o / ovf_o update
//   bcd_o   : packed BCD result, digit 0 in bits [3:0]
//   ovf_o   : result did not fit in DIGITS digits
// ---------------------------------------------------------------------------
interface bcd_result_converter_if #(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3
);
  logic                  start_i;
  logic [WIDTH-1:0]      bin_i;
  logic                  busy_o;
  logic                  done_o;
  logic [4*DIGITS-1:0]   bcd_o;
  logic                  ovf_o;

  modport master (
    output start_i, bin_i,
    input  busy_o, done_o, bcd_o, ovf_o
  );

  modport slave (
    input  start_i, bin_i,
    output busy_o, done_o, bcd_o, ovf_o
  );
endinterface

// File: rtl/bcd_result_converter.sv
// ---------------------------------------------------------------------------
// bcd_result_converter
//   Converts the adder's WIDTH-bit sum to DIGITS packed BCD digits using the
//   shift-and-add-3 (double-dabble) algorithm, one input bit per clock.
//   A conversion takes WIDTH cycles from the accepting edge to done_o.
//
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : bcd_result_converter_if slave modport
//         (start_i, bin_i in; busy_o, done_o, bcd_o, ovf_o out)
// ---------------------------------------------------------------------------
module bcd_result_converter #(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  bcd_result_converter_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   bin_q;
  logic [BCD_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_out_q;
  logic               done_q;

  // FSM decode
  logic               load;
  logic               step;
  logic               finish;

  // One double-dabble iteration computed from the current state
  logic [BCD_W-1:0]   acc_adj;
  logic [BCD_W-1:0]   acc_nxt;
  logic [WIDTH-1:0]   bin_nxt;
  logic               carry_out;
  logic               ovf_nxt;

  // -------------------------------------------------------------------------
  // Iteration datapath: add 3 to each digit >= 5, then shift {acc, bin} left.
  // Digits are corrected independently; no carry crosses a digit boundary.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable driven here gets a default first so no latch is
    // inferred on paths that skip an assignment.
    acc_adj = acc_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) begin
        acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
    end
    {carry_out, acc_nxt, bin_nxt} = {acc_adj, bin_q, 1'b0};
    // The bit leaving the top digit means the value exceeds DIGITS digits;
    // what remains in acc is the value modulo 10^DIGITS.
    ovf_nxt = ovf_q | carry_out;
  end

  // -------------------------------------------------------------------------
  // FSM next-state and control
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = SHIFT;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        step = 1'b1;
        // cnt_q == 1 marks the last iteration; results publish on this edge.
        if (cnt_q == CNT_W'(1)) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath and output registers
  // -------------------------------------------------------------------------
  // NOTE: all datapath registers are reset here; they are plain flops, not a
  // memory array, so an async clear is cheap and keeps outputs defined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      ovf_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= finish;
      if (load) begin
        bin_q <= bus.bin_i;
        acc_q <= '0;
        cnt_q <= CNT_W'(WIDTH);
        ovf_q <= 1'b0;
      end else if (step) begin
        bin_q <= bin_nxt;
        acc_q <= acc_nxt;
        cnt_q <= cnt_q - CNT_W'(1);
        ovf_q <= ovf_nxt;
      end
      if (finish) begin
        bcd_q     <= acc_nxt;
        ovf_out_q <= ovf_nxt;
      end
    end
  end

  assign bus.busy_o = (state_q == SHIFT);
  assign bus.done_o = done_q;
  assign bus.bcd_o  = bcd_q;
  assign bus.ovf_o  = ovf_out_q;

endmodule

// File: tb/tb_bcd_result_converter.sv
// ---------------------------------------------------------------------------
// tb_bcd_result_converter
//   Directed bench for bcd_result_converter. dut_a is WIDTH=9/DIGITS=3,
//   dut_b is WIDTH=9/DIGITS=2 for the overflow cases. Inputs change on the
//   falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_bcd_result_converter;

  logic clk;
  logic rst;

  int n_vec;
  int n_err;

  bcd_result_converter_if #(.WIDTH(9), .DIGITS(3)) if_a ();
  bcd_result_converter_if #(.WIDTH(9), .DIGITS(2)) if_b ();

  bcd_result_converter #(.WIDTH(9), .DIGITS(3)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  bcd_result_converter #(.WIDTH(9), .DIGITS(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input bit sel, input logic s, input logic [8:0] v);
    if (sel) begin
      if_b.start_i = s;
      if_b.bin_i   = v;
    end else begin
      if_a.start_i = s;
      if_a.bin_i   = v;
    end
  endtask

  function automatic logic get_done(input bit sel);
    return sel ? if_b.done_o : if_a.done_o;
  endfunction

  // Launch one conversion and check latency, result, overflow and pulse width.
  task automatic convert(input bit sel, input logic [8:0] v,
                         input logic [11:0] exp_bcd, input logic exp_ovf,
                         input string tag);
    int cycles;
    logic [11:0] got_bcd;
    @(negedge clk);
    set_start(sel, 1'b1, v);
    @(negedge clk);
    set_start(sel, 1'b0, v);
    cycles = 1;
    while (!get_done(sel) && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    got_bcd = sel ? {4'h0, if_b.bcd_o} : if_a.bcd_o;
    check({tag, " latency"}, cycles - 1, 9);
    check({tag, " bcd"}, got_bcd, exp_bcd);
    check({tag, " ovf"}, sel ? if_b.ovf_o : if_a.ovf_o, exp_ovf);
    check({tag, " busy low at done"}, sel ? if_b.busy_o : if_a.busy_o, 0);
    @(negedge clk);
    check({tag, " done single pulse"}, get_done(sel), 0);
  endtask

  initial begin
    int cycles;
    int first_done;
    int second_done;
    int n_done;
    int n_busy;

    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    if_a.start_i = 1'b0;
    if_a.bin_i   = '0;
    if_b.start_i = 1'b0;
    if_b.bin_i   = '0;

    // Reset, then 20 idle cycles with outputs all zero
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle outputs", {if_a.bcd_o, if_a.busy_o, if_a.done_o, if_a.ovf_o}, 0);
    end

    // Basic conversions, DIGITS=3
    convert(1'b0, 9'd0,   12'h000, 1'b0, "conv 0");
    convert(1'b0, 9'd255, 12'h255, 1'b0, "conv 255");
    convert(1'b0, 9'd510, 12'h510, 1'b0, "conv 510");
    convert(1'b0, 9'd511, 12'h511, 1'b0, "conv 511");

    // Back-to-back with bin_i changing after the accepting edge
    @(negedge clk);
    set_start(1'b0, 1'b1, 9'd137);
    @(negedge clk);
    set_start(1'b0, 1'b0, 9'd42);
    cycles = 1;
    while (!if_a.done_o && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    first_done = cycles;
    check("b2b first bcd", if_a.bcd_o, 12'h137);
    set_start(1'b0, 1'b1, 9'd42);
    @(negedge clk);
    cycles++;
    set_start(1'b0, 1'b0, 9'd42);
    while (!if_a.done_o && cycles < 80) begin
      @(negedge clk);
      cycles++;
    end
    second_done = cycles;
    check("b2b second bcd", if_a.bcd_o, 12'h042);
    check("b2b done spacing", second_done - first_done, 10);

    // Start while busy is ignored
    repeat (2) @(negedge clk);
    set_start(1'b0, 1'b1, 9'd300);
    @(negedge clk);
    set_start(1'b0, 1'b0, 9'd300);
    n_done = 0;
    n_busy = 0;
    first_done = 0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 3) set_start(1'b0, 1'b1, 9'd99);
      if (i == 4) set_start(1'b0, 1'b0, 9'd99);
      if (if_a.busy_o) n_busy++;
      if (if_a.done_o) begin
        n_done++;
        if (first_done == 0) first_done = i;
      end
      @(negedge clk);
    end
    check("busy-start done count", n_done, 1);
    check("busy-start latency", first_done - 1, 9);
    check("busy-start busy cycles", n_busy, 9);
    check("busy-start bcd", if_a.bcd_o, 12'h300);

    // Overflow, DIGITS=2
    convert(1'b1, 9'd100, 12'h000, 1'b1, "ovf 100");
    convert(1'b1, 9'd99,  12'h099, 1'b0, "ovf 99");

    // Asynchronous reset mid-conversion
    @(negedge clk);
    set_start(1'b0, 1'b1, 9'd456);
    @(negedge clk);
    set_start(1'b0, 1'b0, 9'd456);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async rst outputs",
          {if_a.bcd_o, if_a.busy_o, if_a.done_o, if_a.ovf_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (if_a.done_o || if_a.busy_o) n_done++;
    end
    check("no done after rst", n_done, 0);
    convert(1'b0, 9'd456, 12'h456, 1'b0, "post-rst 456");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_result_converter.md
# bcd_result_converter

Sequential binary-to-BCD converter that sits directly downstream of the clocked n-bit adder stage. It captures the adder's `width+1`-bit sum (carry included) and converts it with the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It presents packed BCD digits to the calculator's display/output stage. A start/busy/done handshake lets the controller launch a conversion once the sum is valid.

## Interface

Parameters:
- `WIDTH`, default 9: input binary width; equals adder `width` + 1, so the adder carry is included.
- `DIGITS`, default 3: number of BCD digits produced. For overflow-free operation, 10^DIGITS > 2^WIDTH − 1.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start_i`, in, 1: request a conversion of `bin_i`; sampled only in IDLE.
- `bin_i`, in, WIDTH: unsigned binary value, normally adder output `s_o`.
- `busy_o`, out, 1: high while a conversion is in progress.
- `done_o`, out, 1: single-cycle pulse when `bcd_o` and `ovf_o` update.
- `bcd_o`, out, 4*DIGITS: packed BCD result; digit k occupies bits [4k+3:4k], with digit 0 least significant. Held until the next completion.
- `ovf_o`, out, 1: the result did not fit in DIGITS digits; valid with `bcd_o`.

## Operation

- States:
  - IDLE: waiting; `busy_o` = 0.
  - SHIFT: conversion running; `busy_o` = 1.
- Internal registers:
  - shift register `bin_q` (WIDTH bits), loaded from `bin_i`.
  - scratch BCD register `acc_q` (4*DIGITS bits), cleared on start.
  - bit counter `cnt_q`, counting WIDTH iterations, sized ceil(log2(WIDTH+1)).
  - sticky overflow bit `ovf_q`.
- IDLE → SHIFT: on `start_i` = 1. Load `bin_q` ← `bin_i`, clear `acc_q`, set `cnt_q` ← WIDTH, clear `ovf_q`.
- Each SHIFT cycle, one iteration:
  - Every digit of `acc_q` that is ≥ 5 gets +3 (each digit handled independently, 4-bit, no carry between digits).
  - `{acc_q, bin_q}` is shifted left by 1.
  - The bit shifted out of the top of `acc_q` is ORed into `ovf_q`.
  - `cnt_q` decrements.
- SHIFT → IDLE: on the iteration where `cnt_q` = 1. On that same edge:
  - `bcd_o` ← final `acc_q`.
  - `ovf_o` ← final `ovf_q`.
  - `done_o` is set for exactly one cycle.
- `start_i` while in SHIFT is ignored; no queuing.
- `bin_i` is sampled only on the accepting edge; later changes do not affect the running conversion.
- If `ovf_o` = 1, `bcd_o` holds the low DIGITS digits of the value (value mod 10^DIGITS).
- Reset (asynchronous, any state, including mid-conversion):
  - state → IDLE.
  - `busy_o`, `done_o`, `ovf_o` → 0.
  - `bcd_o`, `acc_q`, `bin_q`, `cnt_q`, `ovf_q` → 0.
  - A conversion in progress is discarded; no `done_o` is produced for it.
- Releasing `rst` causes no spurious `done_o`.

## Timing

- `start_i` is accepted at rising edge T0. `busy_o` is high from T0 through T0+WIDTH.
- The iterations occur at edges T0+1 … T0+WIDTH.
- At edge T0+WIDTH: `bcd_o`/`ovf_o` update, `busy_o` falls, and `done_o` is high for the cycle following that edge.
- Latency from start accepted to `done_o` is WIDTH cycles.
- Back-to-back operation: `start_i` may be high in the `done_o` cycle; it is accepted at T0+WIDTH+1. Minimum issue interval is WIDTH+1 cycles.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan

- Reset then idle, WIDTH=9/DIGITS=3: assert `rst` for 2 cycles, then release with `start_i` = 0 for 20 cycles. Required: `bcd_o` = 0x000, `busy_o` = `done_o` = `ovf_o` = 0 throughout.
- Conversions with WIDTH=9/DIGITS=3:
  - `bin_i` = 0 → `bcd_o` = 0x000.
  - `bin_i` = 255 → `bcd_o` = 0x255.
  - `bin_i` = 510 (255+255 from the adder) → `bcd_o` = 0x510.
  - `bin_i` = 511 → `bcd_o` = 0x511.
  - For each: `ovf_o` = 0, and `done_o` is a single pulse exactly 9 cycles after the accepting edge.
- Back-to-back and input stability: start with `bin_i` = 137, change `bin_i` to 42 on the next cycle, and re-assert `start_i` in the `done_o` cycle. Required: first result 0x137, second result 0x042, two `done_o` pulses 10 cycles apart.
- Start while busy: pulse `start_i` with `bin_i` = 99 three cycles into a conversion of 300. Required: exactly one `done_o`, `bcd_o` = 0x300; `busy_o` is not extended.
- Overflow with DIGITS=2, WIDTH=9: `bin_i` = 100 → `bcd_o` = 0x00, `ovf_o` = 1. `bin_i` = 99 → `bcd_o` = 0x99, `ovf_o` = 0.
- Reset mid-conversion: assert `rst` asynchronously (between clock edges) 4 cycles into a conversion of 456. Required: outputs go to 0 immediately and no `done_o` follows. A new start with 456 after reset release → `bcd_o` = 0x456.
